sp3_link_bringup: RTL and testbench
===================================

Name: sp3_link_bringup

Overview:
- Link bring-up sequencer for the SPROCKET3 dual receiver, in the axi_clk domain.
- Pulses the uplink reset and waits for MGT Rx ready.
- While each channel is unlocked, steps the demux word alignment of channels A and B independently with single-cycle bitslip pulses until both lpGBT uplinks report ready.
- Supervises the locked link, re-running the sequence on loss of lock, with bounded retries and a sticky failure state.

Parameters:
- RST_CYCLES, 16: uplinkRst_o high time in cycles.
- MGT_SETTLE, 256: consecutive cycles mgt_rxrdy_i must be high before alignment starts.
- MGT_TIMEOUT, 1048576: maximum cycles in WAIT_MGT before a retry.
- SLIP_WAIT, 4096: cycles per channel between bitslip pulses while that channel is not ready; minimum 4.
- MAX_SLIPS, 64: bitslips per channel per attempt before a retry; at most 255.
- STABLE_CYCLES, 1024: cycles both channels must be continuously ready before LOCKED.
- MAX_RETRIES, 3: failed attempts before FAIL; at most 15.

Ports:
- axi_clk  in  1  controller clock.
- rst_n_i  in  1  Synchronous, active-low reset.
- enable_i  in  1  Run sequencer; low forces IDLE.
- force_relink_i  in  1  Single-cycle pulse: restart from RESET.
- mgt_rxrdy_i  in  1  MGT Rx ready, already synchronised to axi_clk.
- uplinkRdy_a_i  in  1  Uplink A ready, already synchronised to axi_clk.
- uplinkRdy_b_i  in  1  Uplink B ready, already synchronised to axi_clk.
- uplinkRst_o  out  1  Drives receiver uplinkRst_i.
- pulse_bitslip_a_o  out  1  Single-cycle bitslip request, channel A.
- pulse_bitslip_b_o  out  1  Single-cycle bitslip request, channel B.
- state_o  out  3  IDLE=0, RESET=1, WAIT_MGT=2, ALIGN=3, LOCKED=4, FAIL=5.
- locked_o  out  1  High iff state is LOCKED.
- fail_o  out  1  High iff state is FAIL.
- slipcnt_a_o  out  8  Bitslips issued to channel A in the current attempt.
- slipcnt_b_o  out  8  Bitslips issued to channel B in the current attempt.
- retry_cnt_o  out  4  Failed attempts since the last lock or restart.
- loss_cnt_o  out  16  Lock-loss events; saturating; cleared only by reset.

Behaviour:
- Reset (rst_n_i low at a clock edge): state IDLE and every output 0, including all counters and timers.
- All outputs are registered. State transitions take effect on the clock edge after the triggering condition.
- IDLE:
  - uplinkRst_o=0; no bitslip pulses.
  - enable_i high -> RESET; slipcnt_a_o, slipcnt_b_o and retry_cnt_o are cleared.
- RESET:
  - uplinkRst_o=1 for exactly RST_CYCLES cycles, then WAIT_MGT with uplinkRst_o=0.
  - The slip counters are cleared on entry.
- WAIT_MGT:
  - A settle counter increments while mgt_rxrdy_i=1 and clears to 0 when mgt_rxrdy_i=0.
  - Settle counter reaching MGT_SETTLE -> ALIGN.
  - A timeout counter reaching MGT_TIMEOUT -> retry rule.
- ALIGN, applied to channels A and B independently:
  - Each channel has a wait timer.
  - When uplinkRdy_x_i=1, that channel's timer is held at 0.
  - Otherwise the timer increments. On reaching SLIP_WAIT:
    - pulse_bitslip_x_o=1 for one cycle;
    - slipcnt_x_o increments;
    - the timer restarts at 0.
  - A and B may pulse in the same cycle.
  - A stable counter increments while both ready inputs are 1 and clears otherwise. Reaching STABLE_CYCLES -> LOCKED.
  - If either slip counter reaches MAX_SLIPS while that channel is not ready -> retry rule.
  - mgt_rxrdy_i=0 in ALIGN -> retry rule.
- Retry rule:
  - retry_cnt_o increments.
  - If the new value equals MAX_RETRIES -> FAIL; otherwise -> RESET.
- LOCKED:
  - retry_cnt_o is cleared on entry; the slip counters hold their final values.
  - Any of mgt_rxrdy_i, uplinkRdy_a_i or uplinkRdy_b_i at 0 for one cycle counts as a loss:
    - loss_cnt_o increments, saturating at 0xFFFF;
    - state -> RESET.
  - A loss does not increment retry_cnt_o.
- FAIL:
  - uplinkRst_o=0; no pulses; all counters hold.
  - Exit only via enable_i low (-> IDLE) or force_relink_i.
- force_relink_i in any state except IDLE -> RESET, with retry_cnt_o cleared.
- Simultaneous events, in priority order:
  1. rst_n_i
  2. enable_i low
  3. force_relink_i
  4. the state's own transition
- enable_i dropping mid-sequence -> IDLE next cycle; uplinkRst_o drops immediately and any in-flight pulse is suppressed.

Test Plan (RST_CYCLES=4, MGT_SETTLE=8, SLIP_WAIT=16, MAX_SLIPS=4, STABLE_CYCLES=8, MAX_RETRIES=2):
- Clean bring-up:
  - Stimulus: enable_i=1; mgt_rxrdy_i goes high 10 cycles after uplinkRst_o falls; both uplink ready inputs are high by then.
  - Required: uplinkRst_o high exactly 4 cycles; ALIGN after 8 ready cycles; LOCKED 8 cycles later; zero bitslip pulses; locked_o=1.
- Independent slipping:
  - Stimulus: uplinkRdy_a_i rises after 2 A-slips; uplinkRdy_b_i rises after 3 B-slips.
  - Required: pulses spaced 17 cycles apart per channel; slipcnt_a_o=2, slipcnt_b_o=3; then LOCKED.
- Slip exhaustion:
  - Stimulus: uplinkRdy_b_i held 0.
  - Required: after 4 B-slips, retry_cnt_o=1 and RESET; after the second exhaustion, FAIL with fail_o=1 and retry_cnt_o=2.
- MGT timeout and glitch:
  - Stimulus: mgt_rxrdy_i toggles every 5 cycles.
  - Required: the settle counter never completes; after MGT_TIMEOUT cycles the retry rule fires.
- Lock loss:
  - Stimulus: while LOCKED, drop uplinkRdy_a_i for 1 cycle.
  - Required: loss_cnt_o=1; state RESET next cycle; re-lock occurs; retry_cnt_o stays 0.
- Priority and reset:
  - Stimulus 1: force_relink_i and enable_i=0 in the same cycle.
    - Required: IDLE.
  - Stimulus 2: rst_n_i low mid-ALIGN.
    - Required: all outputs 0 next cycle.

Source files
------------

// File: rtl/sp3_link_bringup.sv
// SPROCKET3 dual-receiver link bring-up sequencer (axi_clk domain).
// Resets the uplink, waits for the MGT, bitslips A/B into alignment, supervises lock.
module sp3_link_bringup #(
  parameter int RST_CYCLES    = 16,
  parameter int MGT_SETTLE    = 256,
  parameter int MGT_TIMEOUT   = 1048576,
  parameter int SLIP_WAIT     = 4096,
  parameter int MAX_SLIPS     = 64,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic        axi_clk,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        force_relink_i,
  input  logic        mgt_rxrdy_i,
  input  logic        uplinkRdy_a_i,
  input  logic        uplinkRdy_b_i,
  output logic        uplinkRst_o,
  output logic        pulse_bitslip_a_o,
  output logic        pulse_bitslip_b_o,
  output logic [2:0]  state_o,
  output logic        locked_o,
  output logic        fail_o,
  output logic [7:0]  slipcnt_a_o,
  output logic [7:0]  slipcnt_b_o,
  output logic [3:0]  retry_cnt_o,
  output logic [15:0] loss_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_ALIGN  = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(MGT_SETTLE + 1);
  localparam int TW = $clog2(MGT_TIMEOUT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam int BW = $clog2(STABLE_CYCLES + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(MGT_SETTLE - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(MGT_TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(SLIP_WAIT);
  localparam logic [BW-1:0] STB_LAST  = BW'(STABLE_CYCLES - 1);
  localparam logic [7:0]    SLIP_MAX  = 8'(MAX_SLIPS);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [WW-1:0] tmr_a_q, tmr_a_d;
  logic [WW-1:0] tmr_b_q, tmr_b_d;
  logic [BW-1:0] stable_q, stable_d;
  logic [7:0]    slip_a_q, slip_a_d;
  logic [7:0]    slip_b_q, slip_b_d;
  logic [3:0]    retry_q, retry_d;
  logic [15:0]   loss_q, loss_d;
  logic          urst_q, urst_d;
  logic          pa_q, pa_d;
  logic          pb_q, pb_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;
  logic          retry_hit, entry, both_rdy;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    settle_d  = '0;
    tout_d    = '0;
    tmr_a_d   = '0;
    tmr_b_d   = '0;
    stable_d  = '0;
    slip_a_d  = slip_a_q;
    slip_b_d  = slip_b_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    pa_d      = 1'b0;
    pb_d      = 1'b0;
    retry_hit = 1'b0;
    entry     = 1'b0;
    both_rdy  = uplinkRdy_a_i & uplinkRdy_b_i;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_RESET;
          retry_d = '0;
        end
      end
      S_RESET: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        settle_d = mgt_rxrdy_i ? settle_q + 1'b1 : '0;
        tout_d   = tout_q + 1'b1;
        if (mgt_rxrdy_i && settle_q == SET_LAST) state_d = S_ALIGN;
        else if (tout_q == TO_LAST) retry_hit = 1'b1;
      end
      S_ALIGN: begin
        pa_d     = ~uplinkRdy_a_i & (tmr_a_q == WAIT_MAX);
        pb_d     = ~uplinkRdy_b_i & (tmr_b_q == WAIT_MAX);
        tmr_a_d  = (uplinkRdy_a_i | pa_d) ? '0 : tmr_a_q + 1'b1;
        tmr_b_d  = (uplinkRdy_b_i | pb_d) ? '0 : tmr_b_q + 1'b1;
        slip_a_d = slip_a_q + {7'd0, pa_d};
        slip_b_d = slip_b_q + {7'd0, pb_d};
        stable_d = both_rdy ? stable_q + 1'b1 : '0;
        if (!mgt_rxrdy_i ||
            (!uplinkRdy_a_i && slip_a_q == SLIP_MAX) ||
            (!uplinkRdy_b_i && slip_b_q == SLIP_MAX))
          retry_hit = 1'b1;
        else if (both_rdy && stable_q == STB_LAST)
          state_d = S_LOCKED;
      end
      S_LOCKED: begin
        if (!(mgt_rxrdy_i & both_rdy)) begin
          state_d = S_RESET;
          if (loss_q != 16'hFFFF) loss_d = loss_q + 1'b1;
        end
      end
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase

    if (retry_hit) begin
      retry_d = retry_q + 1'b1;
      state_d = (retry_d == RETRY_MAX) ? S_FAIL : S_RESET;
    end

    if (force_relink_i && state_q != S_IDLE) begin
      state_d = S_RESET;
      retry_d = '0;
      loss_d  = loss_q;
      entry   = 1'b1;
    end

    if (!enable_i) begin
      state_d = S_IDLE;
      retry_d = retry_q;
      loss_d  = loss_q;
      entry   = 1'b1;
    end

    if (state_d != state_q) entry = 1'b1;

    // Every state entry restarts timers and drops any pulse being formed.
    if (entry) begin
      rst_cnt_d = '0;
      settle_d  = '0;
      tout_d    = '0;
      tmr_a_d   = '0;
      tmr_b_d   = '0;
      stable_d  = '0;
      pa_d      = 1'b0;
      pb_d      = 1'b0;
      slip_a_d  = (state_d == S_RESET) ? '0 : slip_a_q;
      slip_b_d  = (state_d == S_RESET) ? '0 : slip_b_q;
      if (state_d == S_LOCKED) retry_d = '0;
    end

    urst_d   = (state_d == S_RESET);
    locked_d = (state_d == S_LOCKED);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge axi_clk) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      settle_q  <= '0;
      tout_q    <= '0;
      tmr_a_q   <= '0;
      tmr_b_q   <= '0;
      stable_q  <= '0;
      slip_a_q  <= '0;
      slip_b_q  <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      urst_q    <= 1'b0;
      pa_q      <= 1'b0;
      pb_q      <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      settle_q  <= settle_d;
      tout_q    <= tout_d;
      tmr_a_q   <= tmr_a_d;
      tmr_b_q   <= tmr_b_d;
      stable_q  <= stable_d;
      slip_a_q  <= slip_a_d;
      slip_b_q  <= slip_b_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      urst_q    <= urst_d;
      pa_q      <= pa_d;
      pb_q      <= pb_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
    end
  end

  assign state_o           = state_q;
  assign uplinkRst_o       = urst_q;
  assign pulse_bitslip_a_o = pa_q;
  assign pulse_bitslip_b_o = pb_q;
  assign locked_o          = locked_q;
  assign fail_o            = fail_q;
  assign slipcnt_a_o       = slip_a_q;
  assign slipcnt_b_o       = slip_b_q;
  assign retry_cnt_o       = retry_q;
  assign loss_cnt_o        = loss_q;

endmodule

// File: tb/tb_sp3_link_bringup.sv
// Testbench for sp3_link_bringup: randomized scenarios checked
// against timing expectations computed from the sequencer's rules.
module tb_sp3_link_bringup;

  localparam int RST_CYCLES    = 4;
  localparam int MGT_SETTLE    = 8;
  localparam int MGT_TIMEOUT   = 64;
  localparam int SLIP_WAIT     = 16;
  localparam int MAX_SLIPS     = 4;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;

  logic        clk = 1'b0;
  logic        rst_n, en, frc, mgt, ra, rb;
  logic        uplinkRst_o, pulse_bitslip_a_o, pulse_bitslip_b_o;
  logic [2:0]  state_o;
  logic        locked_o, fail_o;
  logic [7:0]  slipcnt_a_o, slipcnt_b_o;
  logic [3:0]  retry_cnt_o;
  logic [15:0] loss_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_loss = 0;
  int qa[$];
  int qb[$];

  sp3_link_bringup #(
    .RST_CYCLES(RST_CYCLES), .MGT_SETTLE(MGT_SETTLE),
    .MGT_TIMEOUT(MGT_TIMEOUT), .SLIP_WAIT(SLIP_WAIT),
    .MAX_SLIPS(MAX_SLIPS), .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .axi_clk(clk), .rst_n_i(rst_n), .enable_i(en),
    .force_relink_i(frc), .mgt_rxrdy_i(mgt),
    .uplinkRdy_a_i(ra), .uplinkRdy_b_i(rb),
    .uplinkRst_o(uplinkRst_o),
    .pulse_bitslip_a_o(pulse_bitslip_a_o),
    .pulse_bitslip_b_o(pulse_bitslip_b_o),
    .state_o(state_o), .locked_o(locked_o), .fail_o(fail_o),
    .slipcnt_a_o(slipcnt_a_o), .slipcnt_b_o(slipcnt_b_o),
    .retry_cnt_o(retry_cnt_o), .loss_cnt_o(loss_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference timing model
  function automatic int relock_len();
    return RST_CYCLES + MGT_SETTLE + STABLE_CYCLES;
  endfunction

  function automatic int slip_lock_len(input int na, input int nb);
    int m;
    m = (na > nb) ? na : nb;
    return (SLIP_WAIT + 1) * m + STABLE_CYCLES;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (pulse_bitslip_a_o === 1'b1) qa.push_back(cyc);
    if (pulse_bitslip_b_o === 1'b1) qb.push_back(cyc);
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim,
                            output int n);
    n = 0;
    while (state_o !== s && n <= lim) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; frc = 0; mgt = 0; ra = 0; rb = 0;
    step(); step();
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state_o);
    end
    checks++;
    if ({uplinkRst_o, pulse_bitslip_a_o, pulse_bitslip_b_o,
         locked_o, fail_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got nonzero want 0");
    end
    checks++;
    if ({slipcnt_a_o, slipcnt_b_o, retry_cnt_o, loss_cnt_o} !== 36'd0) begin
      errors++; $display("FAIL reset_counters: got nonzero want 0");
    end
    rst_n = 1;
    step(); step();
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL idle_hold: got %0d want 0", state_o);
    end
  endtask

  task automatic test_clean_bringup();
    int hi, d, n;
    qa.delete(); qb.delete();
    ra = 1; rb = 1; mgt = 0; en = 1;
    step();
    hi = 0;
    while (uplinkRst_o === 1'b1 && hi < 50) begin
      hi++;
      step();
    end
    checks++;
    if (hi != RST_CYCLES) begin
      errors++; $display("FAIL rst_high: got %0d want %0d", hi, RST_CYCLES);
    end
    checks++;
    if (state_o !== 3'd2) begin
      errors++; $display("FAIL wait_mgt: got %0d want 2", state_o);
    end
    d = $urandom_range(6, 14);
    repeat (d) step();
    checks++;
    if (state_o !== 3'd2) begin
      errors++; $display("FAIL no_settle: got %0d want 2", state_o);
    end
    mgt = 1;
    wait_state(3'd3, 40, n);
    checks++;
    if (n != MGT_SETTLE) begin
      errors++; $display("FAIL settle_len: got %0d want %0d", n, MGT_SETTLE);
    end
    wait_state(3'd4, 40, n);
    checks++;
    if (n != STABLE_CYCLES) begin
      errors++; $display("FAIL stable_len: got %0d want %0d", n, STABLE_CYCLES);
    end
    checks++;
    if (locked_o !== 1'b1 || qa.size() + qb.size() != 0) begin
      errors++;
      $display("FAIL clean_lock: got locked=%0b pulses=%0d want 1,0",
               locked_o, qa.size() + qb.size());
    end
  endtask

  task automatic test_slipping(input int na, input int nb);
    int k, t0;
    frc = 1; ra = 0; rb = 0; mgt = 1;
    step();
    frc = 0;
    checks++;
    if (state_o !== 3'd1 || loss_cnt_o !== 16'(exp_loss)) begin
      errors++;
      $display("FAIL force_beats_loss: got st=%0d loss=%0d want 1,%0d",
               state_o, loss_cnt_o, exp_loss);
    end
    wait_state(3'd3, 60, k);
    checks++;
    if (k != RST_CYCLES + MGT_SETTLE) begin
      errors++;
      $display("FAIL align_entry: got %0d want %0d", k, RST_CYCLES + MGT_SETTLE);
    end
    t0 = cyc;
    qa.delete(); qb.delete();
    k = 0;
    while (state_o !== 3'd4 && k < 300) begin
      step();
      k++;
      if (qa.size() >= na) ra = 1;
      if (qb.size() >= nb) rb = 1;
    end
    checks++;
    if (k != slip_lock_len(na, nb)) begin
      errors++;
      $display("FAIL slip_lock_len: got %0d want %0d", k, slip_lock_len(na, nb));
    end
    checks++;
    if (qa.size() != na || qb.size() != nb) begin
      errors++;
      $display("FAIL pulse_count: got %0d,%0d want %0d,%0d",
               qa.size(), qb.size(), na, nb);
    end
    foreach (qa[i]) begin
      checks++;
      if (qa[i] != t0 + (SLIP_WAIT + 1) * (i + 1)) begin
        errors++;
        $display("FAIL a_spacing: got %0d want %0d",
                 qa[i] - t0, (SLIP_WAIT + 1) * (i + 1));
      end
    end
    foreach (qb[i]) begin
      checks++;
      if (qb[i] != t0 + (SLIP_WAIT + 1) * (i + 1)) begin
        errors++;
        $display("FAIL b_spacing: got %0d want %0d",
                 qb[i] - t0, (SLIP_WAIT + 1) * (i + 1));
      end
    end
    checks++;
    if (slipcnt_a_o !== 8'(na) || slipcnt_b_o !== 8'(nb)) begin
      errors++;
      $display("FAIL slipcnt: got %0d,%0d want %0d,%0d",
               slipcnt_a_o, slipcnt_b_o, na, nb);
    end
  endtask

  task automatic test_slip_exhaustion();
    int k, d;
    frc = 1; ra = 1; rb = 0; mgt = 1;
    step();
    frc = 0;
    for (int r = 1; r <= MAX_RETRIES; r++) begin
      wait_state(3'd3, 60, k);
      qb.delete();
      k = 0;
      while (state_o === 3'd3 && k < 300) begin
        step();
        k++;
      end
      checks++;
      if (k != (SLIP_WAIT + 1) * MAX_SLIPS + 1 || qb.size() != MAX_SLIPS) begin
        errors++;
        $display("FAIL exhaust_len: got %0d/%0d want %0d/%0d", k, qb.size(),
                 (SLIP_WAIT + 1) * MAX_SLIPS + 1, MAX_SLIPS);
      end
      checks++;
      if (retry_cnt_o !== 4'(r) ||
          state_o !== ((r == MAX_RETRIES) ? 3'd5 : 3'd1)) begin
        errors++;
        $display("FAIL exhaust_retry: got rc=%0d st=%0d want rc=%0d",
                 retry_cnt_o, state_o, r);
      end
    end
    checks++;
    if (fail_o !== 1'b1 || slipcnt_b_o !== 8'(MAX_SLIPS)) begin
      errors++;
      $display("FAIL fail_entry: got fail=%0b slipb=%0d want 1,%0d",
               fail_o, slipcnt_b_o, MAX_SLIPS);
    end
    d = $urandom_range(5, 30);
    qa.delete(); qb.delete();
    repeat (d) step();
    checks++;
    if (state_o !== 3'd5 || qb.size() != 0 || uplinkRst_o !== 1'b0 ||
        retry_cnt_o !== 4'(MAX_RETRIES)) begin
      errors++;
      $display("FAIL fail_hold: got st=%0d pulses=%0d rc=%0d want 5,0,%0d",
               state_o, qb.size(), retry_cnt_o, MAX_RETRIES);
    end
  endtask

  task automatic test_mgt_timeout();
    int p, ph, w0, i;
    int durs[$];
    int rts[$];
    logic [2:0] sts[$];
    logic [2:0] prev;
    frc = 1; ra = 1; rb = 1;
    step();
    frc = 0;
    p = $urandom_range(1, MGT_SETTLE - 1);
    ph = 0; w0 = 0; i = 0;
    prev = state_o;
    while (state_o !== 3'd5 && i < 400) begin
      ph++;
      if (ph >= p) begin
        mgt = ~mgt;
        ph = 0;
      end
      step();
      i++;
      if (state_o === 3'd2 && prev !== 3'd2) w0 = cyc;
      if (prev === 3'd2 && state_o !== 3'd2) begin
        durs.push_back(cyc - w0);
        sts.push_back(state_o);
        rts.push_back(int'(retry_cnt_o));
      end
      prev = state_o;
    end
    checks++;
    if (durs.size() != MAX_RETRIES) begin
      errors++;
      $display("FAIL timeout_count: got %0d want %0d", durs.size(), MAX_RETRIES);
    end
    foreach (durs[j]) begin
      checks++;
      if (durs[j] != MGT_TIMEOUT || rts[j] != j + 1 ||
          sts[j] !== ((j + 1 == MAX_RETRIES) ? 3'd5 : 3'd1)) begin
        errors++;
        $display("FAIL timeout_retry: got len=%0d rc=%0d st=%0d want %0d,%0d",
                 durs[j], rts[j], sts[j], MGT_TIMEOUT, j + 1);
      end
    end
  endtask

  task automatic test_align_glitch();
    int n;
    frc = 1; mgt = 1; ra = 0; rb = 0;
    step();
    frc = 0;
    wait_state(3'd3, 60, n);
    repeat ($urandom_range(1, SLIP_WAIT - 1)) step();
    mgt = 0;
    step();
    checks++;
    if (state_o !== 3'd1 || retry_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL align_glitch: got st=%0d rc=%0d want 1,1",
               state_o, retry_cnt_o);
    end
    mgt = 1; ra = 1; rb = 1;
    wait_state(3'd4, 80, n);
    checks++;
    if (n != relock_len() || retry_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL lock_clears_retry: got n=%0d rc=%0d want %0d,0",
               n, retry_cnt_o, relock_len());
    end
  endtask

  task automatic test_lock_loss();
    int ch, n;
    for (int j = 0; j < 3; j++) begin
      ch = (j == 0) ? 1 : $urandom_range(0, 2);
      if (ch == 0) mgt = 0;
      else if (ch == 1) ra = 0;
      else rb = 0;
      step();
      mgt = 1; ra = 1; rb = 1;
      exp_loss = sat_inc(exp_loss);
      checks++;
      if (state_o !== 3'd1 || loss_cnt_o !== 16'(exp_loss) ||
          retry_cnt_o !== 4'd0 || locked_o !== 1'b0) begin
        errors++;
        $display("FAIL lock_loss: got st=%0d loss=%0d rc=%0d want 1,%0d,0",
                 state_o, loss_cnt_o, retry_cnt_o, exp_loss);
      end
      wait_state(3'd4, 80, n);
      checks++;
      if (n != relock_len() || retry_cnt_o !== 4'd0) begin
        errors++;
        $display("FAIL relock: got n=%0d rc=%0d want %0d,0",
                 n, retry_cnt_o, relock_len());
      end
    end
  endtask

  task automatic test_priority();
    int n;
    frc = 1; en = 0;
    step();
    frc = 0;
    checks++;
    if (state_o !== 3'd0 || uplinkRst_o !== 1'b0) begin
      errors++; $display("FAIL prio_disable: got st=%0d want 0", state_o);
    end
    frc = 1;
    step();
    frc = 0;
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL force_in_idle: got %0d want 0", state_o);
    end
    en = 1;
    step(); step();
    en = 0;
    step();
    checks++;
    if (state_o !== 3'd0 || uplinkRst_o !== 1'b0) begin
      errors++;
      $display("FAIL disable_in_reset: got st=%0d rst=%0b want 0,0",
               state_o, uplinkRst_o);
    end
    ra = 0; rb = 1; mgt = 1; en = 1;
    wait_state(3'd3, 60, n);
    repeat (SLIP_WAIT) step();
    checks++;
    if (state_o !== 3'd3 || pulse_bitslip_a_o !== 1'b0) begin
      errors++;
      $display("FAIL early_pulse: got st=%0d pa=%0b want 3,0",
               state_o, pulse_bitslip_a_o);
    end
    en = 0;
    step();
    checks++;
    if (state_o !== 3'd0 || pulse_bitslip_a_o !== 1'b0 ||
        slipcnt_a_o !== 8'd0) begin
      errors++;
      $display("FAIL pulse_suppress: got st=%0d pa=%0b sa=%0d want 0,0,0",
               state_o, pulse_bitslip_a_o, slipcnt_a_o);
    end
    en = 1;
    wait_state(3'd3, 60, n);
    repeat (SLIP_WAIT + 3) step();
    checks++;
    if (slipcnt_a_o !== 8'd1) begin
      errors++; $display("FAIL pre_reset_slip: got %0d want 1", slipcnt_a_o);
    end
    rst_n = 0;
    step();
    exp_loss = 0;
    checks++;
    if ({state_o, uplinkRst_o, pulse_bitslip_a_o, pulse_bitslip_b_o,
         locked_o, fail_o, slipcnt_a_o, slipcnt_b_o, retry_cnt_o,
         loss_cnt_o} !== 44'd0) begin
      errors++;
      $display("FAIL reset_mid_align: got st=%0d loss=%0d sa=%0d want 0",
               state_o, loss_cnt_o, slipcnt_a_o);
    end
    rst_n = 1; en = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_slipping(2, 3);
    test_slipping($urandom_range(1, MAX_SLIPS - 1),
                  $urandom_range(1, MAX_SLIPS - 1));
    test_slip_exhaustion();
    test_mgt_timeout();
    test_align_glitch();
    test_lock_loss();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
